// File: rtl/dsi_dist_pkg.sv
// -----------------------------------------------------------------------------
// dsi_dist_pkg
// Shared types and helpers for the DSI lane distributor.
//   LANE_CNT      : number of physical data lanes (4)
//   BYTE_W        : lane byte width (8)
//   ENTRY_W       : width of one lane FIFO entry ({lp, byte})
//   lane_entry_t  : packed {lp, data[7:0]} FIFO entry
//   dist_state_e  : distributor FSM states
//   clamp_lanes() : maps a raw lane-count register to the effective 1..4
//   lane_wrap()   : folds a lane index that is below 2*N back into 0..N-1
// Optional macro DSI_DIST_ERR_EN adds strb_contiguous() for error reporting.
// -----------------------------------------------------------------------------
package dsi_dist_pkg;

   localparam int unsigned LANE_CNT = 4;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned ENTRY_W  = BYTE_W + 1;

   typedef struct packed {
      logic              lp;
      logic [BYTE_W-1:0] data;
   } lane_entry_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } dist_state_e;

   function automatic logic [2:0] clamp_lanes(input logic [2:0] raw);
      if (raw == 3'd0) begin
         return 3'd1;
      end else if (raw >= 3'd4) begin
         return 3'd4;
      end else begin
         return raw;
      end
   endfunction

   // Callers guarantee sum < 2*n, so a single conditional subtract is a full
   // modulo; the result is always below n <= 4 and fits two bits.
   function automatic logic [1:0] lane_wrap(input logic [2:0] sum,
                                            input logic [2:0] n);
      logic [2:0] r;
      r = (sum >= n) ? (sum - n) : sum;
      return r[1:0];
   endfunction

`ifdef DSI_DIST_ERR_EN
   // Legal strobes are a run of ones from bit 0 (0,1,3,7,F): adding one to
   // such a value never carries into a set bit.
   function automatic logic strb_contiguous(input logic [3:0] strb);
      return ((strb & (strb + 4'd1)) == 4'd0);
   endfunction
`endif

endpackage

// File: rtl/dsi_lane_byte_fifo.sv
// -----------------------------------------------------------------------------
// dsi_lane_byte_fifo
// First-word-fall-through FIFO holding lane_entry_t entries for one lane.
//   clk_phy  in   byte clock
//   rst_n    in   asynchronous active-low reset (clears pointers)
//   wr_i     in   push wdata_i
//   wdata_i  in   entry to push
//   rd_i     in   pop head entry; ignored when empty
//   rdata_o  out  head entry, valid whenever empty_o is low, zero when empty
//   empty_o  out  FIFO empty
//   full_o   out  FIFO full
// A push on a full FIFO succeeds when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module dsi_lane_byte_fifo
   import dsi_dist_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic        clk_phy,
   input  logic        rst_n,
   input  logic        wr_i,
   input  lane_entry_t wdata_i,
   input  logic        rd_i,
   output lane_entry_t rdata_o,
   output logic        empty_o,
   output logic        full_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   lane_entry_t mem_q [DEPTH];
   logic [AW:0] wptr_q;
   logic [AW:0] rptr_q;
   logic        do_wr;
   logic        do_rd;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign do_rd = rd_i & ~empty_o;
   // A full FIFO is never empty, so rd_i alone means a slot frees this cycle.
   assign do_wr = wr_i & (~full_o | rd_i);

   // Masking the head keeps stale memory contents off the port after reset.
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_phy or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_wr) wptr_q <= wptr_q + 1'b1;
         if (do_rd) rptr_q <= rptr_q + 1'b1;
      end
   end

   // NOTE: the storage array has no reset; pointers define validity, and a
   // resettable array would cost a flop-based memory for no functional gain.
   always_ff @(posedge clk_phy) begin
      if (do_wr) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/dsi_lane_distributor.sv
// -----------------------------------------------------------------------------
// dsi_lane_distributor
// Spreads packet bytes round-robin over the active DSI data lanes: byte k of a
// packet goes to lane (k mod N). One 32-bit word is held at a time and
// drained up to N bytes per cycle into four per-lane FWFT FIFOs.
//   clk_phy           in   byte clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   in_valid/in_ready      word handshake (in_ready is combinational)
//   in_data  [31:0]   in   packet bytes, byte0 in [7:0]
//   in_strb  [3:0]    in   byte enables (count of set bits, low bytes first)
//   in_last           in   word ends the packet
//   in_lp             in   LP (1) / HS (0) flag copied into every entry
//   reg_lanes_number  in   active lane count, clamped to 1..4 per packet
//   lanes_fifo_data   out  lane i entry at [i*9+:9], bit 8 = LP flag
//   lanes_fifo_empty  out  per-lane FIFO empty
//   lanes_fifo_read   in   per-lane pop
// Optional macro DSI_DIST_ERR_EN adds err_clear (in) and err_flags[1:0] (out):
//   bit0 sticky on non-contiguous strobe, bit1 sticky on out-of-range lane
//   count at sampling; a set in the same cycle beats err_clear.
// -----------------------------------------------------------------------------
module dsi_lane_distributor
   import dsi_dist_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                           clk_phy,
   input  logic                           rst_n,
`ifdef DSI_DIST_ERR_EN
   input  logic                           err_clear,
   output logic [1:0]                     err_flags,
`endif
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [31:0]                    in_data,
   input  logic [3:0]                     in_strb,
   input  logic                           in_last,
   input  logic                           in_lp,
   input  logic [2:0]                     reg_lanes_number,
   output logic [LANE_CNT*ENTRY_W-1:0]    lanes_fifo_data,
   output logic [LANE_CNT-1:0]            lanes_fifo_empty,
   input  logic [LANE_CNT-1:0]            lanes_fifo_read
);

   dist_state_e state_q, state_d;
   logic [31:0] word_q, word_d;
   logic [2:0]  cnt_q, cnt_d;       // valid bytes in the held word (0..4)
   logic        last_q, last_d;
   logic        lp_q, lp_d;
   logic [1:0]  bp_q, bp_d;         // next byte of the held word to drain
   logic [1:0]  lp_ptr_q, lp_ptr_d; // lane receiving that byte
   logic [2:0]  n_q, n_d;           // effective lane count for this packet
   logic        sop_q, sop_d;       // next accepted word starts a packet

   logic [2:0]          rem;
   logic [2:0]          nwr;
   logic [LANE_CNT-1:0] tgt;
   logic [LANE_CNT-1:0] lane_full;
   logic [LANE_CNT-1:0] lane_wr;
   lane_entry_t         lane_wdata [LANE_CNT];
   logic [1:0]          lane_sel;
   logic [1:0]          byte_sel;
   logic [1:0]          ptr_next;
   logic                holding;
   logic                stall;
   logic                final_drain;
   logic                hs;
   logic                n_sample;

   assign holding = (state_q == ST_HOLD);
   assign rem     = cnt_q - {1'b0, bp_q};
   assign nwr     = (rem < n_q) ? rem : n_q;

   // Byte bp+j goes to lane (lp_ptr+j) mod N; nwr <= N keeps lanes distinct.
   // NOTE: every combinational output gets a default before any branch so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      tgt      = '0;
      lane_sel = '0;
      byte_sel = '0;
      for (int l = 0; l < LANE_CNT; l++) lane_wdata[l] = '0;
      for (int j = 0; j < LANE_CNT; j++) begin
         if (3'(j) < nwr) begin
            lane_sel           = lane_wrap({1'b0, lp_ptr_q} + 3'(j), n_q);
            byte_sel           = bp_q + 2'(j);
            tgt[lane_sel]      = 1'b1;
            lane_wdata[lane_sel] = '{lp: lp_q,
                                     data: word_q[{byte_sel, 3'b000} +: BYTE_W]};
         end
      end
   end

   // All-or-nothing: one blocked lane holds back the whole group. A pop on a
   // full lane in the same cycle frees the slot, so it does not stall.
   assign stall       = holding && |(tgt & lane_full & ~lanes_fifo_read);
   assign final_drain = holding && !stall && (nwr == rem);
   assign in_ready    = (state_q == ST_IDLE) || final_drain;
   assign hs          = in_valid && in_ready;
   assign lane_wr     = (holding && !stall) ? tgt : '0;
   assign n_sample    = hs && (state_q == ST_IDLE) && sop_q;
   assign ptr_next    = lane_wrap({1'b0, lp_ptr_q} + nwr, n_q);

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      lp_d     = lp_q;
      bp_d     = bp_q;
      lp_ptr_d = lp_ptr_q;
      n_d      = n_q;
      sop_d    = sop_q;

      if (holding && !stall) begin
         if (final_drain) begin
            state_d  = ST_IDLE;
            bp_d     = '0;
            // Packets always restart on lane 0, even after a zero-strobe word.
            lp_ptr_d = last_q ? 2'd0 : ptr_next;
         end else begin
            // Not final means nwr < rem <= 4, so nwr fits in two bits.
            bp_d     = bp_q + nwr[1:0];
            lp_ptr_d = ptr_next;
         end
      end

      if (hs) begin
         state_d = ST_HOLD;
         word_d  = in_data;
         cnt_d   = 3'($countones(in_strb));
         last_d  = in_last;
         lp_d    = in_lp;
         bp_d    = '0;
         sop_d   = in_last;
         if (n_sample) n_d = clamp_lanes(reg_lanes_number);
      end
   end

   always_ff @(posedge clk_phy or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         word_q   <= '0;
         cnt_q    <= '0;
         last_q   <= 1'b0;
         lp_q     <= 1'b0;
         bp_q     <= '0;
         lp_ptr_q <= '0;
         n_q      <= 3'd1;
         sop_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         lp_q     <= lp_d;
         bp_q     <= bp_d;
         lp_ptr_q <= lp_ptr_d;
         n_q      <= n_d;
         sop_q    <= sop_d;
      end
   end

`ifdef DSI_DIST_ERR_EN
   logic [1:0] err_q, err_d, err_set;

   always_comb begin
      err_set    = '0;
      err_set[0] = hs && !strb_contiguous(in_strb);
      err_set[1] = n_sample &&
                   ((reg_lanes_number == 3'd0) || (reg_lanes_number > 3'd4));
      err_d      = (err_clear ? 2'b00 : err_q) | err_set;
   end

   always_ff @(posedge clk_phy or negedge rst_n) begin
      if (!rst_n) err_q <= '0;
      else        err_q <= err_d;
   end

   assign err_flags = err_q;
`endif

   for (genvar g = 0; g < LANE_CNT; g++) begin : g_lane
      lane_entry_t rdata;

      dsi_lane_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk_phy (clk_phy),
         .rst_n   (rst_n),
         .wr_i    (lane_wr[g]),
         .wdata_i (lane_wdata[g]),
         .rd_i    (lanes_fifo_read[g]),
         .rdata_o (rdata),
         .empty_o (lanes_fifo_empty[g]),
         .full_o  (lane_full[g])
      );

      assign lanes_fifo_data[g*ENTRY_W +: ENTRY_W] = rdata;
   end

endmodule

// File: tb/tb_dsi_lane_distributor.sv
// -----------------------------------------------------------------------------
// tb_dsi_lane_distributor
// Scoreboard bench: each driven word pushes its expected lane entries (lane =
// byte offset in packet mod the bench's own N) into per-lane queues; a reader
// pops the DUT FIFOs and compares against the queue heads.
// -----------------------------------------------------------------------------
module tb_dsi_lane_distributor;

   logic        clk_phy = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [3:0]  in_strb;
   logic        in_last;
   logic        in_lp;
   logic [2:0]  reg_lanes_number;
   logic [35:0] lanes_fifo_data;
   logic [3:0]  lanes_fifo_empty;
   logic [3:0]  lanes_fifo_read;
`ifdef DSI_DIST_ERR_EN
   logic        err_clear;
   logic [1:0]  err_flags;
`endif

   int         n_vec = 0;
   int         n_err = 0;
   logic [8:0] exp_q [4][$];
   int         m_n = 1;          // bench's lane count for the current packet
   int         m_k = 0;          // byte offset within the current packet
   logic [3:0] rd_en = 4'hF;     // continuous draining per lane
   logic [3:0] pop_req = 4'h0;   // one-shot pop per lane

   always #5 clk_phy = ~clk_phy;

   dsi_lane_distributor #(.FIFO_DEPTH(16)) dut (
      .clk_phy          (clk_phy),
      .rst_n            (rst_n),
`ifdef DSI_DIST_ERR_EN
      .err_clear        (err_clear),
      .err_flags        (err_flags),
`endif
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data          (in_data),
      .in_strb          (in_strb),
      .in_last          (in_last),
      .in_lp            (in_lp),
      .reg_lanes_number (reg_lanes_number),
      .lanes_fifo_data  (lanes_fifo_data),
      .lanes_fifo_empty (lanes_fifo_empty),
      .lanes_fifo_read  (lanes_fifo_read)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic reader_loop();
      logic [8:0] entry;
      logic [8:0] want;
      forever begin
         @(negedge clk_phy);
         for (int i = 0; i < 4; i++) begin
            lanes_fifo_read[i] = 1'b0;
            if (rst_n && !lanes_fifo_empty[i] && (rd_en[i] || pop_req[i])) begin
               entry = lanes_fifo_data[i*9 +: 9];
               if (exp_q[i].size() == 0) begin
                  check($sformatf("lane%0d_extra", i), {23'd0, entry}, 32'hDEAD);
               end else begin
                  want = exp_q[i].pop_front();
                  check($sformatf("lane%0d_entry", i), {23'd0, entry}, {23'd0, want});
               end
               lanes_fifo_read[i] = 1'b1;
               pop_req[i]         = 1'b0;
            end
         end
      end
   endtask

   task automatic set_lanes(input int raw, input int n);
      reg_lanes_number = 3'(raw);
      m_n              = n;
   endtask

   // Pushes expectations, then holds the word until in_ready; returns at the
   // falling edge after the handshake with in_valid dropped.
   task automatic send_word(input logic [31:0] d, input logic [3:0] s,
                            input logic l, input logic lp, output int waits);
      int cnt;
      cnt = $countones(s);
      for (int b = 0; b < cnt; b++) begin
         exp_q[m_k % m_n].push_back({lp, d[b*8 +: 8]});
         m_k++;
      end
      if (l) m_k = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_strb  = s;
      in_last  = l;
      in_lp    = lp;
      waits    = 0;
      forever begin
         #2;
         if (in_ready) break;
         waits++;
         if (waits > 100) begin
            check("handshake_timeout", 32'd0, 32'd1);
            break;
         end
         @(negedge clk_phy);
      end
      @(posedge clk_phy);
      @(negedge clk_phy);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int total;
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk_phy);
         #2;
         total = 0;
         for (int i = 0; i < 4; i++) total += exp_q[i].size();
         cyc++;
      end while ((total != 0 || lanes_fifo_empty != 4'hF || !in_ready) && cyc < 300);
      check("drain_pending", 32'(total), 32'd0);
      check("drain_empty", {28'd0, lanes_fifo_empty}, 32'hF);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst_n            = 1'b0;
      in_valid         = 1'b0;
      in_data          = '0;
      in_strb          = '0;
      in_last          = 1'b0;
      in_lp            = 1'b0;
      reg_lanes_number = 3'd1;
      lanes_fifo_read  = '0;
`ifdef DSI_DIST_ERR_EN
      err_clear        = 1'b0;
`endif
      fork
         reader_loop();
      join_none

      // Reset state
      repeat (3) @(negedge clk_phy);
      #2;
      check("rst_empty", {28'd0, lanes_fifo_empty}, 32'hF);
      check("rst_data", {28'd0, lanes_fifo_data[35:32]}, 32'd0);
      check("rst_data_lo", lanes_fifo_data[31:0], 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk_phy);

      // N=4: one word lands on all four lanes in a single cycle
      set_lanes(4, 4);
      send_word(32'h44332211, 4'hF, 1'b1, 1'b0, w);
      #2;
      check("lat_t1_empty", {28'd0, lanes_fifo_empty}, 32'hF);
      check("lat_t1_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk_phy);
      #2;
      check("lat_t2_empty", {28'd0, lanes_fifo_empty}, 32'h0);
      drain();

      // N=1: four bytes serialise on lane 0, in_ready low for 3 cycles
      set_lanes(1, 1);
      send_word(32'h44332211, 4'hF, 1'b1, 1'b0, w);
      send_word(32'h88776655, 4'hF, 1'b1, 1'b0, w);
      check("n1_ready_low", 32'(w), 32'd3);
      drain();

      // Raw 0 clamps to one lane
      set_lanes(0, 1);
      send_word(32'hA3A2A1A0, 4'hF, 1'b0, 1'b0, w);
      send_word(32'h00B2B1B0, 4'h7, 1'b1, 1'b1, w);
      drain();

      // Raw 7 clamps to four lanes, odd tail byte
      set_lanes(7, 4);
      send_word(32'hC3C2C1C0, 4'hF, 1'b0, 1'b1, w);
      send_word(32'hC7C6C5C4, 4'hF, 1'b0, 1'b1, w);
      send_word(32'h000000C8, 4'h1, 1'b1, 1'b1, w);
      drain();

      // N=3 LP packet of six bytes
      set_lanes(3, 3);
      send_word(32'h04030201, 4'hF, 1'b0, 1'b1, w);
      send_word(32'h00000605, 4'h3, 1'b1, 1'b1, w);
      drain();

      // N=3: packet B after a 4-byte packet A restarts on lane 0
      send_word(32'hD3D2D1D0, 4'hF, 1'b1, 1'b0, w);
      send_word(32'h00E2E1E0, 4'h7, 1'b1, 1'b0, w);
      drain();

      // Zero-strobe word with last still restarts the lane pointer
      send_word(32'hF3F2F1F0, 4'hF, 1'b0, 1'b0, w);
      send_word(32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, w);
      send_word(32'h13121110, 4'hF, 1'b1, 1'b1, w);
      drain();

      // Lane count changed mid-packet is ignored until the packet ends
      set_lanes(2, 2);
      send_word(32'h23222120, 4'hF, 1'b0, 1'b0, w);
      repeat (4) @(negedge clk_phy);
      reg_lanes_number = 3'd4;
      send_word(32'h27262524, 4'hF, 1'b1, 1'b0, w);
      drain();
      set_lanes(4, 4);
      send_word(32'h2B2A2928, 4'hF, 1'b1, 1'b0, w);
      drain();

      // N=2, lane 1 not read: fill it, then stall with no partial write
      set_lanes(2, 2);
      rd_en = 4'b1101;
      for (int i = 0; i < 9; i++) begin
         send_word({8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)}, 4'hF,
                   (i == 8), 1'b0, w);
      end
      repeat (6) @(negedge clk_phy);
      #2;
      check("stall_ready", {31'd0, in_ready}, 32'd0);
      check("stall_empty", {28'd0, lanes_fifo_empty}, 32'hD);
      pop_req[1] = 1'b1;
      @(negedge clk_phy);
      #2;
      check("resume_pre_empty", {28'd0, lanes_fifo_empty}, 32'hD);
      @(negedge clk_phy);
      #2;
      check("resume_empty", {28'd0, lanes_fifo_empty}, 32'hC);
      check("resume_ready", {31'd0, in_ready}, 32'd0);
      rd_en = 4'hF;
      drain();

      // Reset with a word held: everything discarded, nothing stale later
      set_lanes(2, 2);
      rd_en = 4'h0;
      send_word(32'hAABBCCDD, 4'hF, 1'b0, 1'b0, w);
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) exp_q[i].delete();
      m_k = 0;
      repeat (2) @(negedge clk_phy);
      #2;
      check("rst2_empty", {28'd0, lanes_fifo_empty}, 32'hF);
      check("rst2_data", lanes_fifo_data[31:0], 32'd0);
      check("rst2_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      rd_en = 4'hF;
      @(negedge clk_phy);
      send_word(32'h0D0C0B0A, 4'hF, 1'b1, 1'b0, w);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
